// File: rtl/bus_transfer_sequencer_if.sv
// bus_transfer_sequencer_if: request and bus-strobe bundle between the requester and the sequencer.
//   req_valid/req_ready/req_src/req_dst : transfer request handshake
//   Rout / Rin                          : one-hot bus-drive and capture strobes
//   xfer_done / xfer_err                : CAPTURE / ERR cycle flags
//   pending / busy                      : queue occupancy and activity status
interface bus_transfer_sequencer_if #(
    parameter int DEPTH = 4,
    parameter int NSRC  = 24
);
    logic                   req_valid;
    logic                   req_ready;
    logic [4:0]             req_src;
    logic [4:0]             req_dst;
    logic [NSRC-1:0]        Rout;
    logic [NSRC-1:0]        Rin;
    logic                   xfer_done;
    logic                   xfer_err;
    logic [$clog2(DEPTH):0] pending;
    logic                   busy;

    modport slave (
        input  req_valid, req_src, req_dst,
        output req_ready, Rout, Rin, xfer_done, xfer_err, pending, busy
    );

    modport master (
        output req_valid, req_src, req_dst,
        input  req_ready, Rout, Rin, xfer_done, xfer_err, pending, busy
    );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: queues {src,dst} register-transfer requests and sequences bus drive/capture strobes.
//   Clock : rising-edge clock
//   clr   : asynchronous active-low reset, flushes the queue and aborts any transfer
//   bus   : slave side of bus_transfer_sequencer_if (request handshake in, strobes and status out)
module bus_transfer_sequencer #(
    parameter int DEPTH = 4,
    parameter int NSRC  = 24
) (
    input  logic                     Clock,
    input  logic                     clr,
    bus_transfer_sequencer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, ERR} state_t;
    typedef struct packed {
        logic [4:0] src;
        logic [4:0] dst;
    } xfer_t;

    state_t         state_q, state_d;
    xfer_t          cur_q, cur_d;
    xfer_t          mem_q [DEPTH];
    xfer_t          head;
    logic [AW-1:0]  wr_q, rd_q;
    logic [PW-1:0]  count_q, count_d;
    logic           push, pop, head_bad;

    // Readiness comes from the registered count only, so a pop in the same
    // cycle never lets a full queue take another entry.
    assign bus.req_ready = count_q < PW'(DEPTH);
    assign push          = bus.req_valid && bus.req_ready;
    // Every state except DRIVE may launch the next queued transfer, which
    // gives back-to-back transfers with no idle gap.
    assign pop           = state_q != DRIVE && count_q != '0;
    assign head          = mem_q[rd_q];
    assign head_bad      = 32'(head.src) >= NSRC || 32'(head.dst) >= NSRC || head.src == head.dst;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        count_d = count_q + PW'(push) - PW'(pop);
        if (state_q == DRIVE) begin
            state_d = CAPTURE;
        end else if (pop) begin
            state_d = head_bad ? ERR : DRIVE;
            cur_d   = head;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            cur_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            count_q <= count_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read once count_q covers it.
    always_ff @(posedge Clock) begin
        if (push) mem_q[wr_q] <= {bus.req_src, bus.req_dst};
    end

    // Strobes decode from registered state only; src/dst are range-checked
    // before DRIVE/CAPTURE, so each shift sets exactly one bit.
    assign bus.Rout      = (state_q == DRIVE || state_q == CAPTURE) ? NSRC'(1) << cur_q.src : '0;
    assign bus.Rin       = (state_q == CAPTURE) ? NSRC'(1) << cur_q.dst : '0;
    assign bus.xfer_done = state_q == CAPTURE;
    assign bus.xfer_err  = state_q == ERR;
    assign bus.pending   = count_q;
    assign bus.busy      = state_q != IDLE || count_q != '0;
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb_bus_transfer_sequencer: directed vector table plus multi-cycle sequences for the transfer sequencer.
module tb_bus_transfer_sequencer;
    localparam int NSRC  = 24;
    localparam int DEPTH = 4;

    logic Clock = 1'b0;
    logic clr   = 1'b0;

    bus_transfer_sequencer_if #(.DEPTH(DEPTH), .NSRC(NSRC)) bus ();
    bus_transfer_sequencer #(.DEPTH(DEPTH), .NSRC(NSRC)) dut (.Clock(Clock), .clr(clr), .bus(bus));

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    int rin_seen = 0;
    int done_log[$];

    typedef struct {
        logic [4:0]      src;
        logic [4:0]      dst;
        logic [NSRC-1:0] rout;
        logic [NSRC-1:0] rin;
        logic            err;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic drive(input logic [4:0] s, input logic [4:0] d);
        bus.req_valid = 1'b1;
        bus.req_src   = s;
        bus.req_dst   = d;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 50) begin
            tick();
            n++;
        end
        chk(name, 32'(n < 50), 1);
    endtask

    function automatic int idx(input logic [NSRC-1:0] v);
        int r = -1;
        for (int i = 0; i < NSRC; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(negedge Clock) begin
        chk("rout_onehot", 32'($countones(bus.Rout) <= 1), 1);
        chk("rin_onehot", 32'($countones(bus.Rin) <= 1), 1);
        if (bus.Rin != '0) rin_seen++;
        if (bus.xfer_done) done_log.push_back(idx(bus.Rout) * 32 + idx(bus.Rin));
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [NSRC-1:0] ch_rout[5];
    logic [NSRC-1:0] ch_rin[5];
    logic            ch_done[5];
    logic            iv_err[3];
    logic [2:0]      iv_pend[3];

    initial begin
        tbl[0] = '{5'd2,  5'd4,  24'h000004, 24'h000010, 1'b0};
        tbl[1] = '{5'd0,  5'd23, 24'h000001, 24'h800000, 1'b0};
        tbl[2] = '{5'd23, 5'd0,  24'h800000, 24'h000001, 1'b0};
        tbl[3] = '{5'd25, 5'd3,  24'h000000, 24'h000000, 1'b1};
        tbl[4] = '{5'd7,  5'd7,  24'h000000, 24'h000000, 1'b1};
        tbl[5] = '{5'd3,  5'd24, 24'h000000, 24'h000000, 1'b1};
        tbl[6] = '{5'd15, 5'd16, 24'h008000, 24'h010000, 1'b0};
        ch_rout = '{24'h000004, 24'h000004, 24'h000010, 24'h000010, 24'h000000};
        ch_rin  = '{24'h000000, 24'h000010, 24'h000000, 24'h000020, 24'h000000};
        ch_done = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        iv_err  = '{1'b1, 1'b1, 1'b0};
        iv_pend = '{3'd1, 3'd0, 3'd0};

        bus.req_valid = 1'b0;
        bus.req_src   = '0;
        bus.req_dst   = '0;
        #2;
        chk("rst_ready", 32'(bus.req_ready), 1);
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_rout", 32'(bus.Rout), 0);
        chk("rst_rin", 32'(bus.Rin), 0);
        chk("rst_done", 32'(bus.xfer_done), 0);
        chk("rst_err", 32'(bus.xfer_err), 0);
        @(negedge Clock);
        clr = 1'b1;

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].src, tbl[i].dst);
            tick();
            bus.req_valid = 1'b0;
            chk($sformatf("v%0d_pend1", i), 32'(bus.pending), 1);
            chk($sformatf("v%0d_rout1", i), 32'(bus.Rout), 0);
            tick();
            chk($sformatf("v%0d_rout2", i), 32'(bus.Rout), 32'(tbl[i].err ? '0 : tbl[i].rout));
            chk($sformatf("v%0d_rin2", i), 32'(bus.Rin), 0);
            chk($sformatf("v%0d_err2", i), 32'(bus.xfer_err), 32'(tbl[i].err));
            chk($sformatf("v%0d_pend2", i), 32'(bus.pending), 0);
            tick();
            chk($sformatf("v%0d_rout3", i), 32'(bus.Rout), 32'(tbl[i].err ? '0 : tbl[i].rout));
            chk($sformatf("v%0d_rin3", i), 32'(bus.Rin), 32'(tbl[i].err ? '0 : tbl[i].rin));
            chk($sformatf("v%0d_done3", i), 32'(bus.xfer_done), 32'(!tbl[i].err));
            chk($sformatf("v%0d_err3", i), 32'(bus.xfer_err), 0);
            tick();
            chk($sformatf("v%0d_busy4", i), 32'(bus.busy), 0);
            chk($sformatf("v%0d_rout4", i), 32'(bus.Rout), 0);
            chk($sformatf("v%0d_rin4", i), 32'(bus.Rin), 0);
        end

        drive(5'd2, 5'd4);
        tick();
        drive(5'd4, 5'd5);
        tick();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("chain%0d_rout", k), 32'(bus.Rout), 32'(ch_rout[k]));
            chk($sformatf("chain%0d_rin", k), 32'(bus.Rin), 32'(ch_rin[k]));
            chk($sformatf("chain%0d_done", k), 32'(bus.xfer_done), 32'(ch_done[k]));
            tick();
        end
        wait_idle("chain_idle");

        drive(5'd25, 5'd3);
        tick();
        drive(5'd7, 5'd7);
        tick();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("inv%0d_err", k), 32'(bus.xfer_err), 32'(iv_err[k]));
            chk($sformatf("inv%0d_pend", k), 32'(bus.pending), 32'(iv_pend[k]));
            chk($sformatf("inv%0d_rout", k), 32'(bus.Rout), 0);
            chk($sformatf("inv%0d_rin", k), 32'(bus.Rin), 0);
            tick();
        end
        wait_idle("inv_idle");

        done_log.delete();
        begin
            int i = 0;
            int cyc = 0;
            logic acc;
            while (i < 8 && cyc < 40) begin
                drive(5'(i), 5'(i + 8));
                acc = bus.req_ready;
                tick();
                cyc++;
                if (acc) i++;
                if (cyc == 7) begin
                    chk("full_ready7", 32'(bus.req_ready), 0);
                    chk("full_pend7", 32'(bus.pending), 4);
                end
                if (cyc == 8) begin
                    chk("full_ready8", 32'(bus.req_ready), 1);
                    chk("full_pend8", 32'(bus.pending), 3);
                end
            end
            bus.req_valid = 1'b0;
            chk("full_accepted", 32'(i), 8);
            chk("full_cycles", 32'(cyc), 9);
        end
        wait_idle("full_idle");
        tick();
        chk("full_count", 32'(done_log.size()), 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("full_order%0d", k), 32'(k < done_log.size() ? done_log[k] : -1), 32'(k * 32 + k + 8));
        end

        drive(5'd2, 5'd4);
        tick();
        drive(5'd1, 5'd3);
        tick();
        drive(5'd5, 5'd6);
        tick();
        bus.req_valid = 1'b0;
        chk("rstmid_pend", 32'(bus.pending), 2);
        chk("rstmid_rin", 32'(bus.Rin), 32'h10);
        #2;
        clr = 1'b0;
        #1;
        chk("rstmid_rout0", 32'(bus.Rout), 0);
        chk("rstmid_rin0", 32'(bus.Rin), 0);
        chk("rstmid_done0", 32'(bus.xfer_done), 0);
        chk("rstmid_pend0", 32'(bus.pending), 0);
        chk("rstmid_busy0", 32'(bus.busy), 0);
        chk("rstmid_ready", 32'(bus.req_ready), 1);
        @(negedge Clock);
        clr = 1'b1;
        rin_seen = 0;
        repeat (6) tick();
        chk("rstmid_no_rin", 32'(rin_seen), 0);
        chk("rstmid_idle", 32'(bus.busy), 0);
        chk("rstmid_no_rout", 32'(bus.Rout), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
